data_mem_unit: RTL and testbench

- Memory-access stage directly downstream of the ALU: takes the ALU result as the byte address and performs loads and stores on an internal word-organised data RAM.
- Supports byte, halfword and word accesses, little-endian, with sign or zero extension on loads.
- Uses a valid/ready request and a single-cycle response pulse, so the control unit can stall the datapath while an access is in flight.

---
 rtl/data_mem_if.sv | 17 +
 rtl/data_mem_unit.sv | 75 +++++++
 tb/tb_data_mem_unit.sv | 93 +++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// data_mem_if: request/response bus between the datapath control and the memory-access stage.
interface data_mem_if #(parameter int DATA_LEN = 32);
  logic                req_valid;
  logic                req_ready;
  logic                mem_write;
  logic [1:0]          size;
  logic                ld_unsigned;
  logic [DATA_LEN-1:0] addr;
  logic [DATA_LEN-1:0] wdata;
  logic                resp_valid;
  logic [DATA_LEN-1:0] rdata;
  logic                err;
  modport master (output req_valid, mem_write, size, ld_unsigned, addr, wdata,
                  input  req_ready, resp_valid, rdata, err);
  modport slave  (input  req_valid, mem_write, size, ld_unsigned, addr, wdata,
                  output req_ready, resp_valid, rdata, err);
endinterface

// File: rtl/data_mem_unit.sv
// data_mem_unit: byte/halfword/word load-store stage on a word-organised RAM, little-endian,
// three-cycle IDLE/ACCESS/RESP handshake.
module data_mem_unit #(
  parameter int DATA_LEN   = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t                r_state, w_next;
  logic                  r_we, r_uns, r_err;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [DATA_LEN-1:0]   r_wdata, r_rdata;
  logic [DATA_LEN-1:0]   r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_err;
  logic [3:0]            w_be;
  logic [DATA_LEN-1:0]   w_wd, w_word, w_load;
  logic [7:0]            w_b;
  logic [15:0]           w_h;
  assign w_idx  = r_addr[ADDR_WIDTH+1:2];
  assign w_err  = (r_size == 2'd3) || (r_size == 2'd1 && r_addr[0]) || (r_size == 2'd2 && r_addr[1:0] != 2'd0);
  assign w_be   = r_size == 2'd0 ? 4'b0001 << r_addr[1:0] : r_size == 2'd1 ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wd   = r_size == 2'd0 ? {4{r_wdata[7:0]}} : r_size == 2'd1 ? {2{r_wdata[15:0]}} : r_wdata;
  assign w_word = r_mem[w_idx];
  assign w_b    = w_word[{r_addr[1:0], 3'b000} +: 8];
  assign w_h    = r_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_load = r_size == 2'd0 ? {{(DATA_LEN-8){~r_uns & w_b[7]}}, w_b}
                : r_size == 2'd1 ? {{(DATA_LEN-16){~r_uns & w_h[15]}}, w_h} : w_word;
  assign bus.req_ready  = r_state == IDLE;
  assign bus.resp_valid = r_state == RESP;
  assign bus.rdata      = r_rdata;
  assign bus.err        = r_err;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.req_valid ? ACCESS : IDLE;
      ACCESS:  w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.req_valid) begin
        r_we    <= bus.mem_write;
        r_size  <= bus.size;
        r_uns   <= bus.ld_unsigned;
        r_addr  <= bus.addr[ADDR_WIDTH+1:0];
        r_wdata <= bus.wdata;
      end
      if (r_state == ACCESS) begin
        r_rdata <= (w_err || r_we) ? '0 : w_load;
        r_err   <= w_err;
      end
    end
  end
  // RAM has no reset; a reset on the ACCESS edge suppresses the write
  always_ff @(posedge clk)
    if (!rst && r_state == ACCESS && r_we && !w_err)
      for (int k = 0; k < 4; k++)
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wd[8*k +: 8];
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: directed scoreboard bench for data_mem_unit.
module tb_data_mem_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];
  data_mem_if #(.DATA_LEN(32)) m ();
  data_mem_unit #(.DATA_LEN(32), .ADDR_WIDTH(10)) dut (.clk(clk), .rst(rst), .bus(m.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] wd);
    m.req_valid = 1'b1; m.mem_write = we; m.size = sz; m.ld_unsigned = uns; m.addr = a; m.wdata = wd;
  endtask
  task automatic req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    logic [32:0] e;
    @(negedge clk);
    chk({tag, " ready"}, {31'd0, m.req_ready}, 32'd1);
    drive(we, sz, uns, a, wd);
    @(posedge clk);
    #1 m.req_valid = 1'b0;
    sb.push_back({exp_err, exp_rd});
    lat = 0;
    do begin @(negedge clk); lat++; end while (!m.resp_valid && lat < 6);
    chk({tag, " latency"}, lat, 2);
    e = sb.pop_front();
    chk({tag, " rdata"}, m.rdata, e[31:0]);
    chk({tag, " err"}, {31'd0, m.err}, {31'd0, e[32]});
  endtask
  initial begin
    drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    m.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset ready", {31'd0, m.req_ready}, 32'd1);
    chk("reset resp", {31'd0, m.resp_valid}, 32'd0);
    chk("reset rdata", m.rdata, 32'd0);
    chk("reset err", {31'd0, m.err}, 32'd0);
    rst = 1'b0;
    req("sw 10",   1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    req("lw 10",   0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    req("sb 11",   1, 2'd0, 0, 32'h11, 32'h55, 32'h0, 0);
    req("lw 10 b", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0);
    req("sh 12",   1, 2'd1, 0, 32'h12, 32'h1234, 32'h0, 0);
    req("lw 10 h", 0, 2'd2, 0, 32'h10, 32'h0, 32'h123455EF, 0);
    req("sw 20",   1, 2'd2, 0, 32'h20, 32'h0000F080, 32'h0, 0);
    req("lb 20",   0, 2'd0, 0, 32'h20, 32'h0, 32'hFFFFFF80, 0);
    req("lbu 20",  0, 2'd0, 1, 32'h20, 32'h0, 32'h00000080, 0);
    req("lh 20",   0, 2'd1, 0, 32'h20, 32'h0, 32'hFFFFF080, 0);
    req("lhu 20",  0, 2'd1, 1, 32'h20, 32'h0, 32'h0000F080, 0);
    req("lbu 21",  0, 2'd0, 1, 32'h21, 32'h0, 32'h000000F0, 0);
    req("sw 22",   1, 2'd2, 0, 32'h22, 32'hFFFFFFFF, 32'h0, 1);
    req("lw 20",   0, 2'd2, 0, 32'h20, 32'h0, 32'h0000F080, 0);
    req("lh 21",   0, 2'd1, 0, 32'h21, 32'h0, 32'h0, 1);
    req("size 11", 0, 2'd3, 0, 32'h20, 32'h0, 32'h0, 1);
    req("sw 1000", 1, 2'd2, 0, 32'h1000, 32'hCAFEF00D, 32'h0, 0);
    req("lw 0",    0, 2'd2, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0);
    @(negedge clk);
    drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk($sformatf("hold ready %0d", i), {31'd0, m.req_ready}, {31'd0, i % 3 == 0});
      chk($sformatf("hold resp %0d", i), {31'd0, m.resp_valid}, {31'd0, i % 3 == 2});
      if (i % 3 == 2) chk($sformatf("hold rdata %0d", i), m.rdata, 32'h123455EF);
    end
    m.req_valid = 1'b0;
    req("sw 30",   1, 2'd2, 0, 32'h30, 32'h11111111, 32'h0, 0);
    @(negedge clk);
    drive(1'b1, 2'd2, 1'b0, 32'h30, 32'hAAAAAAAA);
    @(posedge clk);
    #1 m.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort ready", {31'd0, m.req_ready}, 32'd1);
    chk("abort resp", {31'd0, m.resp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort resp2", {31'd0, m.resp_valid}, 32'd0);
    req("lw 30",   0, 2'd2, 0, 32'h30, 32'h0, 32'h11111111, 0);
    @(negedge clk);
    chk("hold rdata", m.rdata, 32'h11111111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
